// File: rtl/proc_pkg.sv
// Shared processor definitions: stage state encoding, datapath defaults and
// the LW/SW opcodes that decode also uses.
package proc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 6;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // True for the opcodes that touch data memory.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Word accesses need the two byte-offset bits clear.
  function automatic logic word_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for a data-memory acknowledge. The count is 1
// in the first waiting cycle; expire is raised in the cycle whose count equals
// TIMEOUT while enabled, so a request can be held for exactly TIMEOUT cycles.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] FIRST = CW'(1);

  logic [CW-1:0] count;

  // Clear preloads 1 so the first enabled cycle already reads as cycle 1;
  // the count saturates at LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= FIRST;
    end else if (clear) begin
      count <= FIRST;
    end else if (enable && (count != LIMIT)) begin
      count <= count + FIRST;
    end
  end

  // Expiry is only meaningful while the caller is actually waiting.
  always_comb begin
    expire = enable && (count == LIMIT);
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory / write-back stage. Takes one executed instruction from execute,
// performs an optional word LW/SW over a req/ack handshake, then issues one
// register-file write. Only one instruction is ever in flight.
//
// Handshake: an instruction moves from execute into this stage on a cycle
// where ex_valid and ex_ready are both high; ex_ready is high exactly when
// the stage is IDLE. Toward memory, dm_req and its dm_we/dm_addr/dm_wdata
// stay stable until the first cycle with dm_ack high, which completes the
// request (dm_rdata is sampled in that same cycle); dm_req drops on the next
// cycle. dm_ack is ignored whenever no request is outstanding.
module mem_wb_stage
  import proc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rw,
  input  logic              ex_reg_wr,
  input  logic              ex_mem_wr,
  input  logic              ex_memto_reg,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_en,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_misalign,
  output logic              err_timeout,
  output state_e            dbg_state
);

  state_e     state;
  logic [4:0] lat_rw;
  logic       lat_reg_wr;
  logic       lat_load;
  logic       wait_expire;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_MEM),
    .enable (state == ST_MEM),
    .expire (wait_expire)
  );

  // Execute may hand over a new instruction only while nothing is in flight.
  always_comb begin
    ex_ready  = (state == ST_IDLE);
    dbg_state = state;
  end

  // Stage FSM; every memory and write-back output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      wb_en        <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      lat_rw       <= '0;
      lat_reg_wr   <= 1'b0;
      lat_load     <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      wb_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            lat_rw     <= ex_rw;
            lat_reg_wr <= ex_reg_wr;
            // A store-flagged instruction is a store even if memto_reg is set.
            lat_load   <= ex_memto_reg & ~ex_mem_wr;
            if (ex_mem_wr || ex_memto_reg) begin
              if (!word_aligned(ex_alu_result[1:0])) begin
                // Misaligned access is dropped entirely: no request, no write.
                err_misalign <= 1'b1;
              end else begin
                state    <= ST_MEM;
                dm_req   <= 1'b1;
                dm_we    <= ex_mem_wr;
                dm_addr  <= ex_alu_result[ADDR_W+1:2];
                dm_wdata <= ex_store_data;
              end
            end else begin
              state   <= ST_WB;
              wb_en   <= ex_reg_wr & (ex_rw != 5'd0);
              wb_addr <= ex_rw;
              wb_data <= ex_alu_result;
            end
          end
        end
        ST_MEM: begin
          // An acknowledge in the expiry cycle still completes the access.
          if (dm_ack) begin
            dm_req <= 1'b0;
            if (lat_load) begin
              state   <= ST_WB;
              wb_en   <= lat_reg_wr & (lat_rw != 5'd0);
              wb_addr <= lat_rw;
              wb_data <= dm_rdata;
            end else begin
              state <= ST_IDLE;
            end
          end else if (wait_expire) begin
            dm_req      <= 1'b0;
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          dm_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU write-back, LW/SW handshakes,
// misalignment, timeout, x0 suppression and asynchronous reset mid-access.
module tb_mem_wb_stage;
  import proc_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              rst;
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [4:0]        ex_rw;
  logic              ex_reg_wr;
  logic              ex_mem_wr;
  logic              ex_memto_reg;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              err_misalign;
  logic              err_timeout;
  state_e            dbg_state;

  int total_checks;
  int failed_checks;
  int req_cycles;
  int wb_seen;

  mem_wb_stage #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rw         (ex_rw),
    .ex_reg_wr     (ex_reg_wr),
    .ex_mem_wr     (ex_mem_wr),
    .ex_memto_reg  (ex_memto_reg),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .err_misalign  (err_misalign),
    .err_timeout   (err_timeout),
    .dbg_state     (dbg_state)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      failed_checks++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single cycle.
  task automatic drive_op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rw,
                          input logic reg_wr, input logic mem_wr, input logic memto_reg);
    ex_valid      = 1'b1;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_rw         = rw;
    ex_reg_wr     = reg_wr;
    ex_mem_wr     = mem_wr;
    ex_memto_reg  = memto_reg;
    tick();
    ex_valid      = 1'b0;
    ex_mem_wr     = 1'b0;
    ex_memto_reg  = 1'b0;
    ex_reg_wr     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    ex_ready, 1);
    check({tag, "_dm_req"},   dm_req, 0);
    check({tag, "_dm_we"},    dm_we, 0);
    check({tag, "_dm_addr"},  dm_addr, 0);
    check({tag, "_dm_wdata"}, dm_wdata, 0);
    check({tag, "_wb_en"},    wb_en, 0);
    check({tag, "_wb_addr"},  wb_addr, 0);
    check({tag, "_wb_data"},  wb_data, 0);
    check({tag, "_err_mis"},  err_misalign, 0);
    check({tag, "_err_to"},   err_timeout, 0);
    check({tag, "_state"},    dbg_state, ST_IDLE);
  endtask

  initial begin
    total_checks  = 0;
    failed_checks = 0;
    rst           = 1'b1;
    ex_valid      = 1'b0;
    ex_alu_result = '0;
    ex_store_data = '0;
    ex_rw         = '0;
    ex_reg_wr     = 1'b0;
    ex_mem_wr     = 1'b0;
    ex_memto_reg  = 1'b0;
    dm_ack        = 1'b0;
    dm_rdata      = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // ALU op: write-back one cycle after acceptance, ready low for one cycle.
    drive_op(32'h0000_002A, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    check("alu_wb_en",   wb_en, 1);
    check("alu_wb_addr", wb_addr, 5);
    check("alu_wb_data", wb_data, 32'd42);
    check("alu_ready_lo", ex_ready, 0);
    check("alu_no_req",  dm_req, 0);
    tick();
    check("alu_wb_pulse", wb_en, 0);
    check("alu_ready_hi", ex_ready, 1);

    // LW 0x10: request held three cycles, ack with DEADBEEF in the third.
    drive_op(32'h0000_0010, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
    check("lw_state", dbg_state, ST_MEM);
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("lw_req_c%0d", c),  dm_req, 1);
      check($sformatf("lw_we_c%0d", c),   dm_we, 0);
      check($sformatf("lw_addr_c%0d", c), dm_addr, 4);
      check($sformatf("lw_rdy_c%0d", c),  ex_ready, 0);
      if (c == 3) begin
        dm_ack   = 1'b1;
        dm_rdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    check("lw_req_drop", dm_req, 0);
    check("lw_wb_en",    wb_en, 1);
    check("lw_wb_addr",  wb_addr, 7);
    check("lw_wb_data",  wb_data, 32'hDEAD_BEEF);
    tick();
    check("lw_wb_pulse", wb_en, 0);
    check("lw_ready",    ex_ready, 1);

    // SW 0x08 with immediate ack: no write-back, ready the cycle after ack.
    drive_op(32'h0000_0008, 32'h0000_1234, 5'd0, 1'b0, 1'b1, 1'b0);
    check("sw_req",   dm_req, 1);
    check("sw_we",    dm_we, 1);
    check("sw_addr",  dm_addr, 2);
    check("sw_wdata", dm_wdata, 32'h0000_1234);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("sw_req_drop", dm_req, 0);
    check("sw_no_wb",    wb_en, 0);
    check("sw_ready",    ex_ready, 1);

    // Both memory flags set: behaves as a store, never writes a register.
    drive_op(32'h0000_000C, 32'h0000_5A5A, 5'd3, 1'b1, 1'b1, 1'b1);
    check("both_we",   dm_we, 1);
    check("both_addr", dm_addr, 3);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("both_no_wb", wb_en, 0);
    check("both_ready", ex_ready, 1);

    // LW acked exactly in the expiry cycle: normal write-back, no timeout.
    drive_op(32'h0000_003C, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c < TIMEOUT; c++) tick();
    check("late_req_held", dm_req, 1);
    dm_ack   = 1'b1;
    dm_rdata = 32'hCAFE_F00D;
    tick();
    dm_ack   = 1'b0;
    check("late_wb_en",   wb_en, 1);
    check("late_wb_addr", wb_addr, 9);
    check("late_wb_data", wb_data, 32'hCAFE_F00D);
    check("late_no_to",   err_timeout, 0);
    tick();

    // ALU op targeting x0: strobe suppressed, still one busy cycle.
    dm_ack = 1'b1;  // stray ack outside MEM must be ignored
    drive_op(32'h0000_0077, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    dm_ack = 1'b0;
    check("x0_no_wb",   wb_en, 0);
    check("x0_ready_lo", ex_ready, 0);
    check("x0_no_req",  dm_req, 0);
    tick();
    check("x0_ready_hi", ex_ready, 1);

    // Misaligned LW: sticky error, no request, no write-back.
    drive_op(32'h0000_0006, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
    check("mis_err",   err_misalign, 1);
    check("mis_ready", ex_ready, 1);
    req_cycles = 0;
    wb_seen    = 0;
    for (int c = 0; c < 4; c++) begin
      if (dm_req) req_cycles++;
      if (wb_en) wb_seen++;
      tick();
    end
    check("mis_req_never", req_cycles, 0);
    check("mis_wb_never",  wb_seen, 0);
    check("mis_sticky",    err_misalign, 1);

    // LW with no ack: request high exactly TIMEOUT cycles, then abort.
    drive_op(32'h0000_0020, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1);
    req_cycles = 0;
    wb_seen    = 0;
    for (int c = 0; c < TIMEOUT + 5; c++) begin
      if (dm_req) req_cycles++;
      if (wb_en) wb_seen++;
      tick();
    end
    check("to_req_cycles", req_cycles, TIMEOUT);
    check("to_no_wb",      wb_seen, 0);
    check("to_err",        err_timeout, 1);
    check("to_ready",      ex_ready, 1);

    // Reset during MEM: request drops immediately, everything returns to reset.
    drive_op(32'h0000_0010, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1);
    check("rst_pre_req", dm_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    #1;
    rst = 1'b0;
    dm_ack   = 1'b1;
    dm_rdata = 32'h1111_2222;
    tick();
    dm_ack = 1'b0;
    tick();
    check("rst_no_wb",  wb_en, 0);
    check("rst_no_req", dm_req, 0);

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
